// File: rtl/collector_pkg.sv
// Shared types and constants for the block-read collector: FSM states, error bit
// positions and counter width helper.
package collector_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RECV, DONE} state_t;

  localparam int unsigned ERR_W     = 4;
  localparam int unsigned ERR_LEN   = 0;
  localparam int unsigned ERR_OVF   = 1;
  localparam int unsigned ERR_TMO   = 2;
  localparam int unsigned ERR_STRAY = 3;

  // Beat counter must hold DEPTH itself, hence one bit more than the address.
  function automatic int unsigned cntWidth(input int unsigned addrW);
    return addrW + 1;
  endfunction

endpackage

// File: rtl/block_read_collector_if.sv
// Multiplier block-read stream: request/ready handshake plus the valid/data beat stream.
interface block_read_collector_if #(
  parameter int unsigned DATA_W = 16
);
  logic              RDY_mult;
  logic              EN_blockRead;
  logic              VALID_memVal;
  logic [DATA_W-1:0] memVal_data;

  modport master (output RDY_mult, VALID_memVal, memVal_data, input EN_blockRead);
  modport slave  (input RDY_mult, VALID_memVal, memVal_data, output EN_blockRead);
endinterface

// File: rtl/block_read_collector_sync_fifo.sv
// Synchronous FIFO with registered pointers; head word is presented on popData while not empty.
module sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [DATA_W-1:0] popData,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wrPtr, rdPtr;
  logic              doWrite, doRead;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign doWrite = push && (!full || pop);
  assign doRead  = pop && !empty;
  assign popData = mem[rdPtr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr[PTR_W-1:0]] <= pushData;
  end

endmodule

// File: rtl/block_read_collector.sv
// Requests one block read from the multiplier, collects the streamed burst into a sum,
// a beat count and an output FIFO, and flags errors. Optional max tracking: COLLECT_MAX_EN.
module block_read_collector
  import collector_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W:0]          expect_cnt,
  block_read_collector_if.slave    mult,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W:0]          beat_cnt,
  output logic [DATA_W+ADDR_W-1:0] sum,
`ifdef COLLECT_MAX_EN
  output logic [DATA_W-1:0]        max_val,
`endif
  output logic [ERR_W-1:0]         err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = cntWidth(ADDR_W);
  localparam int unsigned SUM_W = DATA_W + ADDR_W;
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_t           stateQ;
  logic [CNT_W-1:0] expQ, beatQ;
  logic [SUM_W-1:0] sumQ;
  logic [TMR_W-1:0] tmrQ;
  logic [ERR_W-1:0] errQ;
  logic             enQ, doneQ;

  logic accept, inBurst, beatValid, room, beatCounted, stray;
  logic fifoPop, fifoFull, fifoEmpty, drop;

  assign accept      = (stateQ == IDLE) && start && mult.RDY_mult;
  assign inBurst     = (stateQ == WAIT) || (stateQ == RECV);
  assign beatValid   = mult.VALID_memVal && inBurst;
  assign room        = beatQ < CNT_W'(DEPTH);
  assign beatCounted = beatValid && room;
  assign stray       = mult.VALID_memVal && !inBurst;
  assign fifoPop     = out_valid && out_ready;
  // Dropped beats are still counted and summed; only the buffered copy is lost.
  assign drop        = beatCounted && fifoFull && !fifoPop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= IDLE;
      expQ   <= '0;
      beatQ  <= '0;
      sumQ   <= '0;
      tmrQ   <= '0;
      errQ   <= '0;
      enQ    <= 1'b0;
      doneQ  <= 1'b0;
    end else begin
      enQ   <= 1'b0;
      doneQ <= 1'b0;
      if (beatCounted) begin
        beatQ <= beatQ + 1'b1;
        sumQ  <= sumQ + SUM_W'(mult.memVal_data);
      end
      if (beatValid && !room) errQ[ERR_LEN]   <= 1'b1;
      if (drop)               errQ[ERR_OVF]   <= 1'b1;
      if (stray)              errQ[ERR_STRAY] <= 1'b1;
      unique case (stateQ)
        IDLE: begin
          if (accept) begin
            stateQ <= REQ;
            expQ   <= expect_cnt;
            beatQ  <= '0;
            sumQ   <= '0;
            errQ   <= '0;
          end
        end
        REQ: begin
          stateQ <= WAIT;
          enQ    <= 1'b1;
          tmrQ   <= '0;
        end
        WAIT: begin
          if (mult.VALID_memVal) begin
            stateQ <= RECV;
          end else if (tmrQ == TMR_W'(TIMEOUT)) begin
            stateQ        <= DONE;
            doneQ         <= 1'b1;
            errQ[ERR_TMO] <= 1'b1;
          end else begin
            tmrQ <= tmrQ + 1'b1;
          end
        end
        RECV: begin
          if (!mult.VALID_memVal) begin
            stateQ <= DONE;
            doneQ  <= 1'b1;
            if (beatQ != expQ) errQ[ERR_LEN] <= 1'b1;
          end
        end
        DONE:    stateQ <= IDLE;
        default: stateQ <= IDLE;
      endcase
    end
  end

`ifdef COLLECT_MAX_EN
  logic [DATA_W-1:0] maxQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maxQ <= '0;
    end else if (accept) begin
      maxQ <= '0;
    end else if (beatCounted && (mult.memVal_data > maxQ)) begin
      maxQ <= mult.memVal_data;
    end
  end

  assign max_val = maxQ;
`endif

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (beatCounted),
    .pushData (mult.memVal_data),
    .pop      (fifoPop),
    .popData  (out_data),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign out_valid         = !fifoEmpty;
  assign mult.EN_blockRead = enQ;
  assign busy              = (stateQ != IDLE);
  assign done              = doneQ;
  assign beat_cnt          = beatQ;
  assign sum               = sumQ;
  assign err               = errQ;

endmodule

// File: tb/tb_block_read_collector.sv
// Directed + randomized bench for block_read_collector with a queue-based burst model.
module tb_block_read_collector;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned TIMEOUT    = 255;
  localparam int unsigned DEPTH      = 64;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [ADDR_W:0]          expect_cnt = '0;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_ready = 1'b0;
  logic                     busy, done;
  logic [ADDR_W:0]          beat_cnt;
  logic [DATA_W+ADDR_W-1:0] sum;
  logic [3:0]               err;
`ifdef COLLECT_MAX_EN
  logic [DATA_W-1:0]        max_val;
`endif

  block_read_collector_if #(.DATA_W(DATA_W)) mult ();

  block_read_collector #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .expect_cnt (expect_cnt),
    .mult       (mult.slave),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .beat_cnt   (beat_cnt),
    .sum        (sum),
`ifdef COLLECT_MAX_EN
    .max_val    (max_val),
`endif
    .err        (err)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;
  int enCnt = 0;
  int doneCnt = 0;
  logic [DATA_W-1:0] got[$];
  int unsigned beats[$];

  always @(posedge clk) begin
    if (mult.EN_blockRead) enCnt <= enCnt + 1;
    if (done) doneCnt <= doneCnt + 1;
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one complete burst from beats[] and checks it against the model.
  task automatic run_burst(input string nm, input int expc, input int n, input bit rdy,
                           input int gate, input bit midStart);
    int          e0, d0, cnt;
    longint      s;
    int unsigned mx;
    logic [3:0]  expErr;
    logic [DATA_W-1:0] expOut[$];

    cnt = (n > DEPTH) ? DEPTH : n;
    s = 0;
    mx = 0;
    for (int i = 0; i < cnt; i++) begin
      s += beats[i];
      if (beats[i] > mx) mx = beats[i];
      if (rdy || i < FIFO_DEPTH) expOut.push_back(beats[i][DATA_W-1:0]);
    end
    expErr = {1'b0, 1'b0, (!rdy && cnt > FIFO_DEPTH), (n != expc)};

    got.delete();
    out_ready = rdy;
    e0 = enCnt;
    d0 = doneCnt;
    start = 1'b1;
    expect_cnt = expc[ADDR_W:0];
    mult.RDY_mult = (gate == 0);
    for (int i = 0; i < gate; i++) step();
    if (gate > 0) begin
      chk({nm, " gated EN"}, 64'(enCnt - e0), 0);
      chk({nm, " gated busy"}, busy, 0);
      mult.RDY_mult = 1'b1;
    end
    step();
    start = 1'b0;
    chk({nm, " busy"}, busy, 1);
    chk({nm, " EN early"}, mult.EN_blockRead, 0);
    step();
    chk({nm, " EN latency"}, mult.EN_blockRead, 1);
    for (int i = 0; i < n; i++) begin
      mult.VALID_memVal = 1'b1;
      mult.memVal_data = beats[i][DATA_W-1:0];
      start = midStart && (i == 1);
      step();
    end
    mult.VALID_memVal = 1'b0;
    mult.memVal_data = '0;
    start = 1'b0;
    for (int k = 0; k < 4 && doneCnt == d0; k++) step();
    chk({nm, " done pulses"}, 64'(doneCnt - d0), 1);
    chk({nm, " EN pulses"}, 64'(enCnt - e0), 1);
    chk({nm, " sum"}, sum, 64'(s));
    chk({nm, " beat_cnt"}, beat_cnt, 64'(cnt));
    chk({nm, " err"}, err, expErr);
`ifdef COLLECT_MAX_EN
    chk({nm, " max_val"}, max_val, 64'(mx));
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 20 && got.size() < expOut.size(); k++) step();
    step();
    chk({nm, " out count"}, 64'(got.size()), 64'(expOut.size()));
    chk({nm, " out drained"}, out_valid, 0);
    for (int i = 0; i < expOut.size() && i < got.size(); i++)
      chk({nm, " out word"}, got[i], expOut[i]);
  endtask

  initial begin
    int         cyc, n, expc;
    logic [DATA_W+ADDR_W-1:0] keepSum;

    mult.RDY_mult = 1'b1;
    mult.VALID_memVal = 1'b0;
    mult.memVal_data = '0;
    repeat (3) step();
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset err", err, 0);
    rst_n = 1'b1;
    step();

    beats = {9, 16, 21, 24, 25, 24, 21, 16, 9};
    run_burst("normal", 9, 9, 1'b1, 0, 1'b0);

    beats = {1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_burst("backpressure", 12, 12, 1'b0, 0, 1'b0);

    beats = {7, 8, 9};
    run_burst("short", 5, 3, 1'b1, 0, 1'b0);

    // Stray beat in IDLE flags an error but leaves the accumulator alone.
    keepSum = sum;
    mult.VALID_memVal = 1'b1;
    mult.memVal_data = 16'h1234;
    step();
    mult.VALID_memVal = 1'b0;
    step();
    chk("stray err", err[3], 1);
    chk("stray sum", sum, keepSum);
    chk("stray busy", busy, 0);

    beats.delete();
    for (int i = 0; i < 6; i++) beats.push_back($urandom_range(0, 65535));
    run_burst("gated", 6, 6, 1'b1, 10, 1'b1);

    // Timeout: request accepted, multiplier never streams.
    got.delete();
    out_ready = 1'b1;
    start = 1'b1;
    expect_cnt = 7'd4;
    step();
    start = 1'b0;
    step();
    chk("tmo EN", mult.EN_blockRead, 1);
    cyc = 0;
    while (!done && cyc < 300) begin
      step();
      cyc++;
    end
    chk("tmo cycles", 64'(cyc), TIMEOUT + 1);
    chk("tmo err", err, 4'b0100);
    chk("tmo beat_cnt", beat_cnt, 0);
    step();
    step();
    chk("tmo busy", busy, 0);
    chk("tmo no output", 64'(got.size()), 0);

    beats.delete();
    for (int i = 0; i < 66; i++) beats.push_back($urandom_range(0, 65535));
    run_burst("saturate", 64, 66, 1'b1, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 12);
      expc = ($urandom_range(0, 1) == 1) ? n : $urandom_range(1, 12);
      beats.delete();
      for (int i = 0; i < n; i++) beats.push_back($urandom_range(0, 65535));
      run_burst($sformatf("rand%0d", r), expc, n, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a burst: everything clears and no done appears.
    out_ready = 1'b0;
    start = 1'b1;
    expect_cnt = 7'd8;
    step();
    start = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      mult.VALID_memVal = 1'b1;
      mult.memVal_data = 16'(i + 3);
      step();
    end
    n = doneCnt;
    #2 rst_n = 1'b0;
    #1;
    mult.VALID_memVal = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst beat_cnt", beat_cnt, 0);
    chk("rst sum", sum, 0);
    chk("rst err", err, 0);
    chk("rst EN", mult.EN_blockRead, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst no done", 64'(doneCnt - n), 0);
    chk("rst fifo empty", out_valid, 0);

    beats = {100, 200, 300, 400, 500};
    run_burst("post reset", 5, 5, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
